univ_shift_reg_rstn: RTL

Parametrised WIDTH-bit universal register with asynchronous active-low reset. It supports hold, logical shift, rotate, arithmetic shift and parallel-load modes, a synchronous clear, and a shift counter that flags each completed WIDTH-shift word. It is the general-purpose successor to the single-bit D flip-flop and serves as the building block for serialisers, deserialisers and delay/rotate datapaths. True and complemented outputs are kept.

---
 rtl/univ_shift_reg_rstn.sv | 135 +++++++++++++
 1 files changed

// File: rtl/univ_shift_reg_rstn.sv
// Universal WIDTH-bit register with asynchronous active-low reset.
// Supports hold, logical shift, rotate, arithmetic shift and parallel load.
// Also has a synchronous clear and a shift counter that flags every completed
// WIDTH-shift word. q is registered; the complement and serial taps are
// combinational views of q.
module univ_shift_reg_rstn #(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    localparam int             CW        = ($clog2(WIDTH) > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             sclr,
    input  logic [2:0]       mode,
    input  logic             ser_in,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_not,
    output logic             ser_out_msb,
    output logic             ser_out_lsb,
    output logic [CW-1:0]    shift_cnt,
    output logic             word_done
);

    typedef enum logic [2:0] {
        MODE_HOLD = 3'd0,
        MODE_SHL  = 3'd1,
        MODE_SHR  = 3'd2,
        MODE_ROL  = 3'd3,
        MODE_ROR  = 3'd4,
        MODE_LOAD = 3'd5,
        MODE_ASR  = 3'd6,
        MODE_RSVD = 3'd7
    } mode_e;

    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             done_q;
    logic             done_d;
    logic             shift_s;
    mode_e            mode_s;

    assign mode_s = mode_e'(mode);

    // Next-state selection: sclr beats the enable gate, which beats the mode.
    always_comb begin
        data_d  = data_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        shift_s = 1'b0;
        if (sclr) begin
            data_d = RESET_VAL;
            cnt_d  = CNT_ZERO;
        end else if (en) begin
            case (mode_s)
                MODE_HOLD: begin
                    data_d = data_q;
                end
                MODE_SHL: begin
                    data_d  = {data_q[WIDTH-2:0], ser_in};
                    shift_s = 1'b1;
                end
                MODE_SHR: begin
                    data_d  = {ser_in, data_q[WIDTH-1:1]};
                    shift_s = 1'b1;
                end
                MODE_ROL: begin
                    data_d  = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
                    shift_s = 1'b1;
                end
                MODE_ROR: begin
                    data_d  = {data_q[0], data_q[WIDTH-1:1]};
                    shift_s = 1'b1;
                end
                MODE_LOAD: begin
                    data_d = d;
                    cnt_d  = CNT_ZERO;
                end
                MODE_ASR: begin
                    data_d  = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
                    shift_s = 1'b1;
                end
                MODE_RSVD: begin
                    data_d = data_q;
                end
                default: begin
                    data_d = data_q;
                end
            endcase
            // Every executed shift advances the word counter; the last bit of a word wraps it.
            if (shift_s) begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d  = CNT_ZERO;
                    done_d = 1'b1;
                end else begin
                    cnt_d  = cnt_q + CNT_ONE;
                    done_d = 1'b0;
                end
            end else begin
                done_d = 1'b0;
            end
        end else begin
            data_d = data_q;
            cnt_d  = cnt_q;
        end
    end

    // State registers, cleared immediately when reset_n falls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= RESET_VAL;
            cnt_q  <= CNT_ZERO;
            done_q <= 1'b0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign q           = data_q;
    assign q_not       = ~data_q;
    assign ser_out_msb = data_q[WIDTH-1];
    assign ser_out_lsb = data_q[0];
    assign shift_cnt   = cnt_q;
    assign word_done   = done_q;

endmodule
